// File: rtl/inv_bank_pkg.sv
// Shared types and reset constants for the clocked inverter bank.
package inv_bank_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BUF  = 2'd0,
    MODE_INV  = 2'd1,
    MODE_TOG  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  localparam mode_t       MODE_RST = MODE_BUF;
  localparam int unsigned FILT_RST = 0;

endpackage

// File: rtl/inv_bank_chan.sv
// One channel: input synchroniser, glitch filter, and mode-selected output register.
module inv_bank_chan
  import inv_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic [MODE_W-1:0] mode,
  input  logic [FILT_W-1:0] filt,
  input  logic              cfg_hit,
  output logic              dout
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   filtered;
  logic                   filt_next;
  logic [FILT_W-1:0]      cnt;
  logic [FILT_W-1:0]      cnt_next;
  logic                   dout_next;

  assign s = sync[SYNC_STAGES-1];

  // Qualify a change only after filt+1 consecutive mismatching edges; a config hit restarts qualification.
  always_comb begin
    filt_next = filtered;
    cnt_next  = '0;
    if (!cfg_hit && (s != filtered)) begin
      if (cnt >= filt) filt_next = s;
      else             cnt_next  = cnt + FILT_W'(1);
    end
  end

  // dout doubles as the toggle state, so entering TOG starts from the current output.
  always_comb begin
    dout_next = dout;
    case (mode_t'(mode))
      MODE_BUF:  dout_next = filt_next;
      MODE_INV:  dout_next = ~filt_next;
      MODE_TOG:  dout_next = dout ^ (filt_next & ~filtered);
      MODE_HOLD: dout_next = dout;
      default:   dout_next = dout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      filtered <= 1'b0;
      cnt      <= '0;
      dout     <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], din};
      filtered <= filt_next;
      cnt      <= cnt_next;
      dout     <= dout_next;
    end
  end

endmodule

// File: rtl/inverter_bank_ctrl.sv
// Bank of NCH filtered digital channels with per-channel mode/filter config over a valid/ready port.
module inverter_bank_ctrl
  import inv_bank_pkg::*;
#(
  parameter  int unsigned NCH         = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned FILT_W      = 3,
  localparam int unsigned CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    din,
  output logic [NCH-1:0]    dout,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [FILT_W-1:0] cfg_filt,
  output logic              cfg_err
);

  logic [MODE_W-1:0] mode_q [NCH];
  logic [FILT_W-1:0] filt_q [NCH];
  logic [NCH-1:0]    hit_c;
  logic              accept_c;
  logic              in_range_c;

  assign accept_c   = cfg_valid & cfg_ready;
  assign in_range_c = 32'(cfg_ch) < NCH;

  // Handshake: one busy (apply) cycle after every accepted write; range error reported in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= ~accept_c;
      cfg_err   <= accept_c & ~in_range_c;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit_c[i] = accept_c & (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q[i] <= MODE_RST;
        filt_q[i] <= FILT_W'(FILT_RST);
      end else if (hit_c[i]) begin
        mode_q[i] <= cfg_mode;
        filt_q[i] <= cfg_filt;
      end
    end

    inv_bank_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .din    (din[i]),
      .mode   (mode_q[i]),
      .filt   (filt_q[i]),
      .cfg_hit(hit_c[i]),
      .dout   (dout[i])
    );
  end

endmodule

// File: tb/tb_inverter_bank_ctrl.sv
// Directed scoreboard bench for inverter_bank_ctrl (NCH=4 main instance, NCH=3 range-error instance).
module tb_inverter_bank_ctrl;
  import inv_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] dout;
  logic       cfg_valid, cfg_ready, cfg_err;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_filt;

  logic [2:0] din3, dout3;
  logic       cfg_valid3, cfg_ready3, cfg_err3;
  logic [1:0] cfg_ch3;
  logic [1:0] cfg_mode3;
  logic [2:0] cfg_filt3;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inverter_bank_ctrl #(.NCH(4)) u_dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_filt(cfg_filt), .cfg_err(cfg_err)
  );

  inverter_bank_ctrl #(.NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .dout(dout3),
    .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
    .cfg_mode(cfg_mode3), .cfg_filt(cfg_filt3), .cfg_err(cfg_err3)
  );

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
      return;
    end
    e = sb_q.pop_front();
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accepting edge with cfg_valid already dropped.
  task automatic cfg_write(input logic [1:0] ch, input mode_t m, input logic [2:0] f);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = m;
    cfg_filt  = f;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic tog;
    rst = 1'b1; din = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_filt = '0;
    din3 = '0; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_mode3 = '0; cfg_filt3 = '0;
    #2;
    push("rst_dout", 8'h0);  check({4'b0, dout});
    push("rst_ready", 8'h1); check({7'b0, cfg_ready});
    push("rst_err", 8'h0);   check({7'b0, cfg_err});
    tick(); tick();
    rst = 1'b0;
    tick();

    // Latency with defaults: 3 edges
    din = 4'b0101;
    tick(); push("lat_e1", 8'h0); check({4'b0, dout});
    tick(); push("lat_e2", 8'h0); check({4'b0, dout});
    tick(); push("lat_e3", 8'h5); check({4'b0, dout});
    push("lat_ready", 8'h1); check({7'b0, cfg_ready});

    // ch1 -> INV
    cfg_write(2'd1, MODE_INV, 3'd0);
    push("inv_busy", 8'h0);  check({7'b0, cfg_ready});
    push("inv_accept_dout", 8'h5); check({4'b0, dout});
    tick();
    push("inv_dout", 8'h7);  check({4'b0, dout});
    push("inv_ready", 8'h1); check({7'b0, cfg_ready});

    // ch2 F=3: glitch rejection and qualified change
    cfg_write(2'd2, MODE_BUF, 3'd3);
    tick();
    din = 4'b0001;
    repeat (8) tick();
    push("f3_low", 8'h3); check({4'b0, dout});
    din = 4'b0101;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) din = 4'b0001;
      tick();
      push("f3_glitch", 8'h3); check({4'b0, dout});
    end
    din = 4'b0101;
    repeat (5) tick();
    push("f3_e5", 8'h3); check({4'b0, dout});
    tick();
    push("f3_e6", 8'h7); check({4'b0, dout});

    // ch0 TOG: three rising pulses
    din = 4'b0100;
    repeat (3) tick();
    push("tog_pre", 8'h6); check({4'b0, dout});
    cfg_write(2'd0, MODE_TOG, 3'd0);
    tick();
    push("tog_entry", 8'h6); check({4'b0, dout});
    tog = 1'b0;
    for (int p = 0; p < 3; p++) begin
      din = 4'b0101;
      repeat (5) tick();
      tog = ~tog;
      push("tog_high", {4'b0, 3'b011, tog}); check({4'b0, dout});
      din = 4'b0100;
      repeat (5) tick();
      push("tog_low", {4'b0, 3'b011, tog}); check({4'b0, dout});
    end

    // ch3 HOLD
    din = 4'b1100;
    repeat (3) tick();
    push("hold_pre", 8'hF); check({4'b0, dout});
    cfg_write(2'd3, MODE_HOLD, 3'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      din[3] = 1'($urandom_range(1, 0));
      tick();
      push("hold_keep", 8'h1); check({7'b0, dout[3]});
    end
    din[3] = 1'b0;
    repeat (4) tick();
    push("hold_low_din", 8'h1); check({7'b0, dout[3]});
    cfg_write(2'd3, MODE_BUF, 3'd0);
    push("unhold_accept", 8'h1); check({7'b0, dout[3]});
    tick();
    push("unhold_next", 8'h0); check({7'b0, dout[3]});

    // Reset during busy cycle
    cfg_write(2'd1, MODE_TOG, 3'd0);
    push("mid_busy", 8'h0); check({7'b0, cfg_ready});
    rst = 1'b1;
    #1;
    push("mid_rst_ready", 8'h1); check({7'b0, cfg_ready});
    push("mid_rst_dout", 8'h0);  check({4'b0, dout});
    tick();
    rst = 1'b0;
    din = 4'b1111;
    repeat (2) tick();
    push("post_rst_e2", 8'h0); check({4'b0, dout});
    tick();
    push("post_rst_buf", 8'hF); check({4'b0, dout});

    // NCH=3: out-of-range writes held valid back to back
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode3 = 2'(MODE_INV); cfg_filt3 = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      push("err_ready", {7'b0, 1'(i % 2)}); check({7'b0, cfg_ready3});
      push("err_pulse", {7'b0, 1'((i + 1) % 2)}); check({7'b0, cfg_err3});
    end
    cfg_valid3 = 1'b0;
    din3 = 3'b101;
    repeat (3) tick();
    push("err_modes_kept", 8'h5); check({5'b0, dout3});
    push("err_cleared", 8'h0); check({7'b0, cfg_err3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
